// File: rtl/fir_pkg.sv
// Shared constants, state encoding and sizing helpers for the FIR MAC branch.
package fir_pkg;

    localparam int unsigned TapsDefault  = 10;
    localparam int unsigned DataWDefault = 16;
    localparam int unsigned CntW         = 5;

    localparam logic signed [31:0] Q15Round = 32'sd16384;
    localparam logic signed [15:0] SatMax   = 16'sh7FFF;
    localparam logic signed [15:0] SatMin   = 16'sh8000;

    typedef logic [1:0] fsmState_t;
    localparam fsmState_t StIdle = 2'd0;
    localparam fsmState_t StMac  = 2'd1;
    localparam fsmState_t StDone = 2'd2;

    // Full product width plus growth for summing `taps` products.
    function automatic int unsigned accWidth(input int unsigned taps, input int unsigned dataW);
        return 2 * dataW + $clog2(taps);
    endfunction

endpackage

// File: rtl/fir_coeff_rf.sv
// Q15 coefficient register file: write port gated to IDLE, combinational read by tap index.
module fir_coeff_rf
    import fir_pkg::*;
#(
    parameter int unsigned TAPS   = TapsDefault,
    parameter int unsigned DATA_W = DataWDefault
) (
    input  logic              iClk_12M,
    input  logic              iRst,
    input  logic              iIdle,
    input  logic              iWrEn,
    input  logic [CntW-1:0]   iWrAddr,
    input  logic [DATA_W-1:0] iWrData,
    input  logic [CntW-1:0]   iRdAddr,
    output logic [DATA_W-1:0] oRdData
);

    logic [DATA_W-1:0] coeffQ [TAPS];

    // Addresses at or above TAPS match no entry and are silently dropped.
    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst) begin
            for (int k = 0; k < TAPS; k++) coeffQ[k] <= '0;
        end else if (iWrEn && iIdle) begin
            for (int k = 0; k < TAPS; k++) begin
                if (iWrAddr == CntW'(k)) coeffQ[k] <= iWrData;
            end
        end
    end

    always_comb begin
        oRdData = '0;
        for (int k = 0; k < TAPS; k++) begin
            if (iRdAddr == CntW'(k)) oRdData = coeffQ[k];
        end
    end

endmodule

// File: rtl/fir_mac_engine.sv
// Time-multiplexed FIR branch: delay line, one MAC per clock, Q15 round and saturate.
module fir_mac_engine
    import fir_pkg::*;
#(
    parameter int unsigned TAPS   = TapsDefault,
    parameter int unsigned DATA_W = DataWDefault
) (
    input  logic              iClk_12M,
    input  logic              iRst,
    input  logic              iEnSample_600k,
    input  logic              iEnDelay,
    input  logic [DATA_W-1:0] iFirIn,
    input  logic              iCoeffWr,
    input  logic [CntW-1:0]   iCoeffAddr,
    input  logic [DATA_W-1:0] iCoeffData,
    output logic [DATA_W-1:0] oMac,
    output logic              oMacValid,
    output logic              oBusy,
    output logic              oOverrun
);

    localparam int unsigned AccW  = accWidth(TAPS, DATA_W);
    localparam int unsigned ProdW = 2 * DATA_W;

    fsmState_t              stateQ, stateD;
    logic [CntW-1:0]        tapQ, tapD;
    logic signed [AccW-1:0] accQ, accD;
    logic [DATA_W-1:0]      macQ, macD;
    logic                   validQ, validD;
    logic                   overrunQ, overrunD;
    logic [DATA_W-1:0]      xQ [TAPS];

    logic                   strobe, idle, shiftEn;
    logic [DATA_W-1:0]      xSel, cSel, satVal;
    logic signed [ProdW-1:0] prod;
    logic signed [AccW-1:0] rounded, shifted;

    assign strobe  = iEnSample_600k & iEnDelay;
    assign idle    = (stateQ == StIdle);
    assign shiftEn = strobe & idle;

    fir_coeff_rf #(
        .TAPS   (TAPS),
        .DATA_W (DATA_W)
    ) uCoeffRf (
        .iClk_12M (iClk_12M),
        .iRst     (iRst),
        .iIdle    (idle),
        .iWrEn    (iCoeffWr),
        .iWrAddr  (iCoeffAddr),
        .iWrData  (iCoeffData),
        .iRdAddr  (tapQ),
        .oRdData  (cSel)
    );

    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst) begin
            for (int k = 0; k < TAPS; k++) xQ[k] <= '0;
        end else if (shiftEn) begin
            xQ[0] <= iFirIn;
            for (int k = 1; k < TAPS; k++) xQ[k] <= xQ[k-1];
        end
    end

    always_comb begin
        xSel = '0;
        for (int k = 0; k < TAPS; k++) begin
            if (tapQ == CntW'(k)) xSel = xQ[k];
        end
    end

    assign prod    = ProdW'($signed(xSel)) * ProdW'($signed(cSel));
    assign rounded = accQ + AccW'(Q15Round);
    assign shifted = rounded >>> 15;

    always_comb begin
        if (shifted > AccW'(SatMax)) begin
            satVal = DATA_W'(SatMax);
        end else if (shifted < AccW'(SatMin)) begin
            satVal = DATA_W'(SatMin);
        end else begin
            satVal = shifted[DATA_W-1:0];
        end
    end

    always_comb begin
        stateD   = stateQ;
        tapD     = tapQ;
        accD     = accQ;
        macD     = macQ;
        validD   = 1'b0;
        // Anything arriving while busy is dropped, but the loss is remembered.
        overrunD = overrunQ | (~idle & (strobe | iCoeffWr));
        unique case (stateQ)
            StIdle: begin
                if (strobe) begin
                    stateD = StMac;
                    tapD   = '0;
                    accD   = '0;
                end
            end
            StMac: begin
                accD = accQ + AccW'(prod);
                tapD = tapQ + 1'b1;
                if (tapQ == CntW'(TAPS - 1)) stateD = StDone;
            end
            StDone: begin
                macD   = satVal;
                validD = 1'b1;
                stateD = StIdle;
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst) begin
            stateQ   <= StIdle;
            tapQ     <= '0;
            accQ     <= '0;
            macQ     <= '0;
            validQ   <= 1'b0;
            overrunQ <= 1'b0;
        end else begin
            stateQ   <= stateD;
            tapQ     <= tapD;
            accQ     <= accD;
            macQ     <= macD;
            validQ   <= validD;
            overrunQ <= overrunD;
        end
    end

    assign oMac      = macQ;
    assign oMacValid = validQ;
    assign oBusy     = ~idle;
    assign oOverrun  = overrunQ;

endmodule
